gbar_client: RTL and testbench



---
 rtl/gbar_client_pkg.sv | 34 +++
 rtl/gbar_client_if.sv | 28 ++
 rtl/gbar_client_slot.sv | 84 ++++++++
 rtl/gbar_client.sv | 111 +++++++++++
 tb/tb_gbar_client.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gbar_client_pkg.sv
// gbar_client_pkg: shared widths, gbar bus payload types and slot state encoding.
// Contents:
//   clog2_min1            - clog2 clamped to at least 1 bit
//   NW/NB/NC_WIDTH        - field widths for the default 4-warp/4-barrier/4-core build
//   gbar_req_t/gbar_rsp_t - global barrier request/response payloads
//   slot_state_e          - per-barrier-ID slot lifecycle
package gbar_client_pkg;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NW_WIDTH = clog2_min1(4);
    localparam int NB_WIDTH = clog2_min1(4);
    localparam int NC_WIDTH = clog2_min1(4);

    typedef struct packed {
        logic [NB_WIDTH-1:0] id;
        logic [NC_WIDTH-1:0] size_m1;
        logic [NC_WIDTH-1:0] core_id;
    } gbar_req_t;

    typedef struct packed {
        logic [NB_WIDTH-1:0] id;
    } gbar_rsp_t;

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_COLLECT,
        SLOT_SEND,
        SLOT_WAIT
    } slot_state_e;

endpackage

// File: rtl/gbar_client_if.sv
// gbar_client_if: global barrier bus between a core-side client and the cluster unit.
// Signals:
//   req_valid/req_ready           - request handshake (client -> unit)
//   req_id/req_size_m1/req_core_id - barrier ID, participating cores minus 1, issuing core
//   rsp_valid/rsp_id              - one-cycle release broadcast (unit -> all clients)
// Modports: master (client side), slave (global unit side).
interface gbar_client_if import gbar_client_pkg::*; #(
    parameter int BW = NB_WIDTH,
    parameter int CW = NC_WIDTH
);
    logic          req_valid;
    logic          req_ready;
    logic [BW-1:0] req_id;
    logic [CW-1:0] req_size_m1;
    logic [CW-1:0] req_core_id;
    logic          rsp_valid;
    logic [BW-1:0] rsp_id;

    modport master (
        output req_valid, req_id, req_size_m1, req_core_id,
        input  req_ready, rsp_valid, rsp_id
    );

    modport slave (
        input  req_valid, req_id, req_size_m1, req_core_id,
        output req_ready, rsp_valid, rsp_id
    );
endinterface

// File: rtl/gbar_client_slot.sv
// gbar_client_slot: lifecycle of one barrier ID (collect warps, request, wait for release).
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   arr_fire                    - accepted arrival targeting this ID
//   arr_wid/arr_wcnt_m1/arr_ccnt_m1 - arriving warp, local warps expected - 1, cores - 1
//   grant                       - this slot's request was accepted by the global unit
//   rsp_hit                     - release broadcast names this ID
//   ready/send/waiting          - slot can take arrivals / requesting / awaiting release
//   mask, ccnt_m1               - arrived warps, latched core count - 1
module gbar_client_slot import gbar_client_pkg::*; #(
    parameter int NUM_WARPS = 4,
    parameter int NUM_CORES = 4,
    localparam int NW_WIDTH = clog2_min1(NUM_WARPS),
    localparam int NC_WIDTH = clog2_min1(NUM_CORES),
    localparam int PC_WIDTH = clog2_min1(NUM_WARPS + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arr_fire,
    input  logic [NW_WIDTH-1:0]  arr_wid,
    input  logic [NW_WIDTH-1:0]  arr_wcnt_m1,
    input  logic [NC_WIDTH-1:0]  arr_ccnt_m1,
    input  logic                 grant,
    input  logic                 rsp_hit,
    output logic                 ready,
    output logic                 send,
    output logic                 waiting,
    output logic [NUM_WARPS-1:0] mask,
    output logic [NC_WIDTH-1:0]  ccnt_m1
);
    slot_state_e          state_q, state_d;
    logic [NUM_WARPS-1:0] wid_oh, new_mask;
    logic [PC_WIDTH-1:0]  pop, target;

    // Count is taken on the mask including this arrival; target is widened
    // before the +1 so a full-core barrier is not truncated.
    always_comb begin
        wid_oh   = NUM_WARPS'(1) << arr_wid;
        new_mask = mask | wid_oh;
        pop      = '0;
        for (int w = 0; w < NUM_WARPS; w++)
            pop = pop + PC_WIDTH'(new_mask[w]);
        target = PC_WIDTH'(arr_wcnt_m1) + PC_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SLOT_IDLE;
            mask    <= '0;
            ccnt_m1 <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == SLOT_WAIT && rsp_hit)
                mask <= '0;
            else if (arr_fire)
                mask <= new_mask;
            if (arr_fire)
                ccnt_m1 <= arr_ccnt_m1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SLOT_IDLE, SLOT_COLLECT: if (arr_fire) state_d = (pop == target) ? SLOT_SEND : SLOT_COLLECT;
            SLOT_SEND:               if (grant)    state_d = SLOT_WAIT;
            SLOT_WAIT:               if (rsp_hit)  state_d = SLOT_IDLE;
            default:                 state_d = SLOT_IDLE;
        endcase
    end

    always_comb begin
        ready   = state_q == SLOT_IDLE || state_q == SLOT_COLLECT;
        send    = state_q == SLOT_SEND;
        waiting = state_q == SLOT_WAIT;
    end

    // A warp arriving twice at the same barrier is a scheduler bug; it is
    // absorbed harmlessly but flagged.
    always_ff @(posedge clk) begin
        if (!reset && arr_fire)
            assert ((mask & wid_oh) == '0);
    end
endmodule

// File: rtl/gbar_client.sv
// gbar_client: core-side global barrier initiator.
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   arr_*              - warp arrival from the scheduler (valid/ready, id, wid, wcnt_m1, ccnt_m1)
//   gbar               - master side of the global barrier bus
//   rel_valid/rel_id/rel_wmask - one-cycle release pulse with the warps to unstall
module gbar_client import gbar_client_pkg::*; #(
    parameter int NUM_WARPS    = 4,
    parameter int NUM_BARRIERS = 4,
    parameter int NUM_CORES    = 4,
    parameter int CORE_ID      = 0,
    localparam int NW_WIDTH = clog2_min1(NUM_WARPS),
    localparam int NB_WIDTH = clog2_min1(NUM_BARRIERS),
    localparam int NC_WIDTH = clog2_min1(NUM_CORES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arr_valid,
    output logic                 arr_ready,
    input  logic [NB_WIDTH-1:0]  arr_id,
    input  logic [NW_WIDTH-1:0]  arr_wid,
    input  logic [NW_WIDTH-1:0]  arr_wcnt_m1,
    input  logic [NC_WIDTH-1:0]  arr_ccnt_m1,
    gbar_client_if.master        gbar,
    output logic                 rel_valid,
    output logic [NB_WIDTH-1:0]  rel_id,
    output logic [NUM_WARPS-1:0] rel_wmask
);
    logic [NUM_BARRIERS-1:0] arr_sel, arr_fire, rsp_hit, grant, win_oh;
    logic [NUM_BARRIERS-1:0] slot_ready, slot_send, slot_wait;
    logic [NUM_WARPS-1:0]    slot_mask [NUM_BARRIERS];
    logic [NC_WIDTH-1:0]     slot_ccnt [NUM_BARRIERS];
    logic [NB_WIDTH-1:0]     win_id;
    logic [NC_WIDTH-1:0]     win_ccnt;
    logic                    rel_hit;
    logic [NUM_WARPS-1:0]    rel_mask_d;

    // Decoding by comparison keeps out-of-range IDs harmless for non-power-of-2 counts.
    always_comb begin
        for (int i = 0; i < NUM_BARRIERS; i++) begin
            arr_sel[i] = arr_id == NB_WIDTH'(i);
            rsp_hit[i] = gbar.rsp_valid && gbar.rsp_id == NB_WIDTH'(i);
        end
    end

    assign arr_ready = |(arr_sel & slot_ready);
    assign arr_fire  = (arr_valid && arr_ready) ? arr_sel : '0;

    for (genvar i = 0; i < NUM_BARRIERS; i++) begin : g_slot
        gbar_client_slot #(
            .NUM_WARPS (NUM_WARPS),
            .NUM_CORES (NUM_CORES)
        ) u_slot (
            .clk         (clk),
            .reset       (reset),
            .arr_fire    (arr_fire[i]),
            .arr_wid     (arr_wid),
            .arr_wcnt_m1 (arr_wcnt_m1),
            .arr_ccnt_m1 (arr_ccnt_m1),
            .grant       (grant[i]),
            .rsp_hit     (rsp_hit[i]),
            .ready       (slot_ready[i]),
            .send        (slot_send[i]),
            .waiting     (slot_wait[i]),
            .mask        (slot_mask[i]),
            .ccnt_m1     (slot_ccnt[i])
        );
    end

    // Fixed priority, lowest ID wins: scan downward so the last hit is the lowest.
    always_comb begin
        win_oh   = '0;
        win_id   = '0;
        win_ccnt = '0;
        for (int i = NUM_BARRIERS - 1; i >= 0; i--) begin
            if (slot_send[i]) begin
                win_oh    = '0;
                win_oh[i] = 1'b1;
                win_id    = NB_WIDTH'(i);
                win_ccnt  = slot_ccnt[i];
            end
        end
    end

    assign gbar.req_valid   = |slot_send;
    assign gbar.req_id      = win_id;
    assign gbar.req_size_m1 = win_ccnt;
    assign gbar.req_core_id = NC_WIDTH'(CORE_ID);
    assign grant            = (gbar.req_valid && gbar.req_ready) ? win_oh : '0;

    // Responses for slots not waiting belong to other cores' barriers and are dropped.
    always_comb begin
        rel_mask_d = '0;
        for (int i = 0; i < NUM_BARRIERS; i++)
            if (rsp_hit[i] && slot_wait[i]) rel_mask_d = slot_mask[i];
    end

    assign rel_hit = |(rsp_hit & slot_wait);

    always_ff @(posedge clk) begin
        if (reset) begin
            rel_valid <= 1'b0;
            rel_id    <= '0;
            rel_wmask <= '0;
        end else begin
            rel_valid <= rel_hit;
            rel_id    <= rel_hit ? gbar.rsp_id : '0;
            rel_wmask <= rel_mask_d;
        end
    end
endmodule

// File: tb/tb_gbar_client.sv
// tb_gbar_client: directed scenarios plus randomized traffic against a barrier-episode model.
module tb_gbar_client;
    localparam int NW  = 4;
    localparam int NB  = 4;
    localparam int NC  = 4;
    localparam int CID = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       arr_valid, arr_ready;
    logic [1:0] arr_id, arr_wid, arr_wcnt_m1, arr_ccnt_m1;
    logic       rel_valid;
    logic [1:0] rel_id;
    logic [3:0] rel_wmask;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    gbar_client_if #(.BW(2), .CW(2)) bus ();

    gbar_client #(
        .NUM_WARPS    (NW),
        .NUM_BARRIERS (NB),
        .NUM_CORES    (NC),
        .CORE_ID      (CID)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .arr_valid   (arr_valid),
        .arr_ready   (arr_ready),
        .arr_id      (arr_id),
        .arr_wid     (arr_wid),
        .arr_wcnt_m1 (arr_wcnt_m1),
        .arr_ccnt_m1 (arr_ccnt_m1),
        .gbar        (bus),
        .rel_valid   (rel_valid),
        .rel_id      (rel_id),
        .rel_wmask   (rel_wmask)
    );

    task automatic idle();
        arr_valid = 0; arr_id = 0; arr_wid = 0; arr_wcnt_m1 = 0; arr_ccnt_m1 = 0;
        bus.req_ready = 0; bus.rsp_valid = 0; bus.rsp_id = 0;
    endtask

    task automatic next();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle(); reset = 1; next(); next(); reset = 0;
    endtask

    task automatic arrive(input int id, input int wid, input int wcnt, input int ccnt);
        arr_valid = 1; arr_id = 2'(id); arr_wid = 2'(wid); arr_wcnt_m1 = 2'(wcnt); arr_ccnt_m1 = 2'(ccnt);
    endtask

    task automatic respond(input int id);
        bus.rsp_valid = 1; bus.rsp_id = 2'(id);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (bus.req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", bus.req_valid); end
        checks++; if (rel_valid !== 1'b0) begin errors++; $display("FAIL reset_rel_valid: got %b want 0", rel_valid); end
        checks++; if (rel_wmask !== 4'b0) begin errors++; $display("FAIL reset_rel_wmask: got %b want 0000", rel_wmask); end
        checks++; if (rel_id !== 2'd0) begin errors++; $display("FAIL reset_rel_id: got %0d want 0", rel_id); end
        for (int i = 0; i < NB; i++) begin
            arr_id = 2'(i); #1;
            checks++; if (arr_ready !== 1'b1) begin errors++; $display("FAIL reset_arr_ready id%0d: got %b want 1", i, arr_ready); end
        end
        next();
    endtask

    task automatic test_single();
        int order [4] = '{0, 2, 1, 3};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            arrive(1, order[k], 3, 1);
            @(negedge clk);
            checks++; if (arr_ready !== 1'b1) begin errors++; $display("FAIL single_arr_ready k%0d: got %b want 1", k, arr_ready); end
            next();
            arr_valid = 0;
            checks++; if (bus.req_valid !== (k == 3)) begin errors++; $display("FAIL single_req_valid k%0d: got %b want %b", k, bus.req_valid, k == 3); end
        end
        checks++; if (bus.req_id !== 2'd1) begin errors++; $display("FAIL single_req_id: got %0d want 1", bus.req_id); end
        checks++; if (bus.req_size_m1 !== 2'd1) begin errors++; $display("FAIL single_req_size: got %0d want 1", bus.req_size_m1); end
        checks++; if (bus.req_core_id !== 2'(CID)) begin errors++; $display("FAIL single_req_core: got %0d want %0d", bus.req_core_id, CID); end
        bus.req_ready = 1; next(); bus.req_ready = 0;
        checks++; if (bus.req_valid !== 1'b0) begin errors++; $display("FAIL single_req_drop: got %b want 0", bus.req_valid); end
        respond(1);
        next();
        bus.rsp_valid = 0;
        checks++; if (rel_valid !== 1'b1) begin errors++; $display("FAIL single_rel_valid: got %b want 1", rel_valid); end
        checks++; if (rel_id !== 2'd1) begin errors++; $display("FAIL single_rel_id: got %0d want 1", rel_id); end
        checks++; if (rel_wmask !== 4'b1111) begin errors++; $display("FAIL single_rel_wmask: got %b want 1111", rel_wmask); end
        arr_id = 1;
        @(negedge clk);
        checks++; if (arr_ready !== 1'b1) begin errors++; $display("FAIL single_reopen: got %b want 1", arr_ready); end
        next();
        checks++; if (rel_valid !== 1'b0) begin errors++; $display("FAIL single_rel_pulse: got %b want 0", rel_valid); end
    endtask

    task automatic test_wcnt0();
        do_reset();
        arrive(0, 2, 0, 3);
        next();
        arr_valid = 0;
        checks++; if (bus.req_valid !== 1'b1 || bus.req_id !== 2'd0 || bus.req_size_m1 !== 2'd3) begin
            errors++; $display("FAIL wcnt0_req: got v%b id%0d sz%0d want v1 id0 sz3", bus.req_valid, bus.req_id, bus.req_size_m1); end
        @(negedge clk);
        checks++; if (arr_ready !== 1'b0) begin errors++; $display("FAIL wcnt0_busy: got %b want 0", arr_ready); end
        next();
        bus.req_ready = 1; next(); bus.req_ready = 0;
        respond(0); next(); bus.rsp_valid = 0;
        checks++; if (rel_valid !== 1'b1 || rel_wmask !== 4'b0100) begin
            errors++; $display("FAIL wcnt0_rel: got v%b m%b want v1 m0100", rel_valid, rel_wmask); end
    endtask

    task automatic test_priority();
        do_reset();
        arrive(2, 1, 0, 1);
        next();
        checks++; if (bus.req_valid !== 1'b1 || bus.req_id !== 2'd2) begin
            errors++; $display("FAIL prio_first: got v%b id%0d want v1 id2", bus.req_valid, bus.req_id); end
        arrive(0, 3, 0, 3);
        next();
        arr_valid = 0;
        checks++; if (bus.req_id !== 2'd0 || bus.req_size_m1 !== 2'd3) begin
            errors++; $display("FAIL prio_preempt: got id%0d sz%0d want id0 sz3", bus.req_id, bus.req_size_m1); end
        for (int s = 0; s < 3; s++) begin
            next();
            checks++; if (bus.req_valid !== 1'b1 || bus.req_id !== 2'd0 || bus.req_size_m1 !== 2'd3) begin
                errors++; $display("FAIL prio_stall%0d: got v%b id%0d sz%0d want v1 id0 sz3", s, bus.req_valid, bus.req_id, bus.req_size_m1); end
        end
        bus.req_ready = 1;
        next();
        checks++; if (bus.req_valid !== 1'b1 || bus.req_id !== 2'd2 || bus.req_size_m1 !== 2'd1) begin
            errors++; $display("FAIL prio_second: got v%b id%0d sz%0d want v1 id2 sz1", bus.req_valid, bus.req_id, bus.req_size_m1); end
        next();
        bus.req_ready = 0;
        checks++; if (bus.req_valid !== 1'b0) begin errors++; $display("FAIL prio_empty: got %b want 0", bus.req_valid); end
        respond(0); next(); respond(2);
        checks++; if (rel_valid !== 1'b1 || rel_id !== 2'd0 || rel_wmask !== 4'b1000) begin
            errors++; $display("FAIL prio_rel0: got v%b id%0d m%b want v1 id0 m1000", rel_valid, rel_id, rel_wmask); end
        next(); bus.rsp_valid = 0;
        checks++; if (rel_valid !== 1'b1 || rel_id !== 2'd2 || rel_wmask !== 4'b0010) begin
            errors++; $display("FAIL prio_rel2: got v%b id%0d m%b want v1 id2 m0010", rel_valid, rel_id, rel_wmask); end
    endtask

    task automatic test_wait_block();
        do_reset();
        arrive(3, 0, 0, 0); next(); arr_valid = 0;
        bus.req_ready = 1; next(); bus.req_ready = 0;
        for (int s = 0; s < 2; s++) begin
            arrive(3, 1, 0, 0);
            @(negedge clk);
            checks++; if (arr_ready !== 1'b0) begin errors++; $display("FAIL wait_block%0d: got %b want 0", s, arr_ready); end
            next();
        end
        arrive(1, 2, 1, 2);
        @(negedge clk);
        checks++; if (arr_ready !== 1'b1) begin errors++; $display("FAIL wait_other: got %b want 1", arr_ready); end
        next();
        checks++; if (bus.req_valid !== 1'b0) begin errors++; $display("FAIL wait_collect: got %b want 0", bus.req_valid); end
        arrive(3, 1, 0, 0);
        respond(3);
        @(negedge clk);
        checks++; if (arr_ready !== 1'b0) begin errors++; $display("FAIL wait_rsp_cycle: got %b want 0", arr_ready); end
        next();
        bus.rsp_valid = 0;
        checks++; if (rel_valid !== 1'b1 || rel_wmask !== 4'b0001) begin
            errors++; $display("FAIL wait_rel: got v%b m%b want v1 m0001", rel_valid, rel_wmask); end
        @(negedge clk);
        checks++; if (arr_ready !== 1'b1) begin errors++; $display("FAIL wait_reopen: got %b want 1", arr_ready); end
        next();
        arr_valid = 0;
        checks++; if (bus.req_valid !== 1'b1 || bus.req_id !== 2'd3) begin
            errors++; $display("FAIL wait_rearm: got v%b id%0d want v1 id3", bus.req_valid, bus.req_id); end
        checks++; if (rel_valid !== 1'b0) begin errors++; $display("FAIL wait_rel_pulse: got %b want 0", rel_valid); end
    endtask

    task automatic test_stray();
        do_reset();
        respond(2);
        arrive(1, 0, 0, 1);
        next();
        idle();
        checks++; if (rel_valid !== 1'b0) begin errors++; $display("FAIL stray_rel: got %b want 0", rel_valid); end
        checks++; if (bus.req_valid !== 1'b1 || bus.req_id !== 2'd1) begin
            errors++; $display("FAIL stray_arr: got v%b id%0d want v1 id1", bus.req_valid, bus.req_id); end
        arr_id = 2;
        @(negedge clk);
        checks++; if (arr_ready !== 1'b1) begin errors++; $display("FAIL stray_state: got %b want 1", arr_ready); end
        next();
    endtask

    task automatic test_simul();
        do_reset();
        arrive(0, 0, 0, 1); next(); arr_valid = 0;
        bus.req_ready = 1; next(); bus.req_ready = 0;
        arrive(2, 3, 0, 2); next();
        respond(0); bus.req_ready = 1; arrive(1, 1, 0, 0);
        @(negedge clk);
        checks++; if (bus.req_id !== 2'd2) begin errors++; $display("FAIL simul_win: got %0d want 2", bus.req_id); end
        next();
        idle();
        checks++; if (rel_valid !== 1'b1 || rel_id !== 2'd0 || rel_wmask !== 4'b0001) begin
            errors++; $display("FAIL simul_rel: got v%b id%0d m%b want v1 id0 m0001", rel_valid, rel_id, rel_wmask); end
        checks++; if (bus.req_valid !== 1'b1 || bus.req_id !== 2'd1 || bus.req_size_m1 !== 2'd0) begin
            errors++; $display("FAIL simul_req: got v%b id%0d sz%0d want v1 id1 sz0", bus.req_valid, bus.req_id, bus.req_size_m1); end
        respond(2); next(); bus.rsp_valid = 0;
        checks++; if (rel_valid !== 1'b1 || rel_id !== 2'd2 || rel_wmask !== 4'b1000) begin
            errors++; $display("FAIL simul_rel2: got v%b id%0d m%b want v1 id2 m1000", rel_valid, rel_id, rel_wmask); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        arrive(1, 1, 0, 0); next(); arr_valid = 0;
        bus.req_ready = 1; next(); bus.req_ready = 0;
        arrive(2, 0, 3, 0); next(); arr_valid = 0;
        reset = 1; next(); reset = 0;
        checks++; if (bus.req_valid !== 1'b0 || rel_valid !== 1'b0 || rel_id !== 2'd0 || rel_wmask !== 4'b0) begin
            errors++; $display("FAIL rmid_outputs: got rv%b lv%b id%0d m%b want all 0", bus.req_valid, rel_valid, rel_id, rel_wmask); end
        arr_id = 1;
        @(negedge clk);
        checks++; if (arr_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b want 1", arr_ready); end
        next();
        respond(1); next(); bus.rsp_valid = 0;
        checks++; if (rel_valid !== 1'b0) begin errors++; $display("FAIL rmid_norel: got %b want 0", rel_valid); end
        arrive(2, 3, 1, 0); next(); arr_valid = 0;
        checks++; if (bus.req_valid !== 1'b0) begin errors++; $display("FAIL rmid_mask_drop: got %b want 0", bus.req_valid); end
    endtask

    // Model: each ID holds a barrier episode = set of arrived warps plus its
    // target size; complete episodes are requested lowest-ID first, and an
    // issued episode is released (and forgotten) by a matching response.
    bit [3:0] m_set    [NB];
    int       m_target [NB];
    int       m_ccnt   [NB];
    bit       m_issued [NB];

    task automatic test_random();
        bit       e_rel_v = 0;
        int       e_rel_id = 0;
        bit [3:0] e_rel_mask = 0;
        do_reset();
        for (int i = 0; i < NB; i++) begin m_set[i] = 0; m_target[i] = 0; m_ccnt[i] = 0; m_issued[i] = 0; end
        for (int cyc = 0; cyc < 800; cyc++) begin
            int  id, w, wc, cc, win, rid;
            bit  e_ready, e_req_v, hit;
            bit  complete [NB];
            for (int i = 0; i < NB; i++) complete[i] = m_set[i] != 0 && $countones(m_set[i]) == m_target[i];
            id = $urandom_range(0, NB - 1);
            wc = (m_set[id] == 0) ? $urandom_range(0, NW - 1) : m_target[id] - 1;
            cc = (m_set[id] == 0) ? $urandom_range(0, NC - 1) : m_ccnt[id];
            w  = $urandom_range(0, NW - 1);
            if (!complete[id]) while (m_set[id][w]) w = $urandom_range(0, NW - 1);
            arr_valid = ($urandom_range(0, 1) == 1);
            arr_id = 2'(id); arr_wid = 2'(w); arr_wcnt_m1 = 2'(wc); arr_ccnt_m1 = 2'(cc);
            bus.req_ready = ($urandom_range(0, 1) == 1);
            rid = $urandom_range(0, NB - 1);
            bus.rsp_valid = ($urandom_range(0, 2) == 0);
            bus.rsp_id = 2'(rid);
            e_ready = !complete[id];
            e_req_v = 0; win = 0;
            for (int i = NB - 1; i >= 0; i--) if (complete[i] && !m_issued[i]) begin e_req_v = 1; win = i; end
            @(negedge clk);
            checks++; if (arr_ready !== e_ready) begin errors++; $display("FAIL rnd_arr_ready c%0d: got %b want %b", cyc, arr_ready, e_ready); end
            checks++; if (bus.req_valid !== e_req_v) begin errors++; $display("FAIL rnd_req_valid c%0d: got %b want %b", cyc, bus.req_valid, e_req_v); end
            if (e_req_v) begin
                checks++; if (bus.req_id !== 2'(win) || bus.req_size_m1 !== 2'(m_ccnt[win]) || bus.req_core_id !== 2'(CID)) begin
                    errors++; $display("FAIL rnd_req_data c%0d: got id%0d sz%0d core%0d want id%0d sz%0d core%0d", cyc,
                        bus.req_id, bus.req_size_m1, bus.req_core_id, win, m_ccnt[win], CID); end
            end
            checks++; if (rel_valid !== e_rel_v) begin errors++; $display("FAIL rnd_rel_valid c%0d: got %b want %b", cyc, rel_valid, e_rel_v); end
            if (e_rel_v) begin
                checks++; if (rel_id !== 2'(e_rel_id) || rel_wmask !== e_rel_mask) begin
                    errors++; $display("FAIL rnd_rel_data c%0d: got id%0d m%b want id%0d m%b", cyc, rel_id, rel_wmask, e_rel_id, e_rel_mask); end
            end
            hit = bus.rsp_valid && m_issued[rid];
            e_rel_v = hit; e_rel_id = rid; e_rel_mask = hit ? m_set[rid] : 4'b0;
            if (hit) begin m_set[rid] = 0; m_issued[rid] = 0; end
            if (e_req_v && bus.req_ready) m_issued[win] = 1;
            if (arr_valid && e_ready) begin
                if (m_set[id] == 0) m_target[id] = wc + 1;
                m_set[id] = m_set[id] | 4'(1 << w);
                m_ccnt[id] = cc;
            end
            next();
        end
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        idle();
        reset = 1;
        test_reset();
        test_single();
        test_wcnt0();
        test_priority();
        test_wait_block();
        test_stray();
        test_simul();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
